cpu_mem_loader: RTL and testbench



---
 rtl/cpu_mem_loader_pkg.sv | 30 +++
 rtl/cpu_mem_loader_sync.sv | 46 ++++
 rtl/cpu_mem_loader.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_mem_loader.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_loader_pkg.sv
// rtl/cpu_mem_loader_pkg.sv - shared types and defaults for the CPU memory loader
//
// Purpose: command and FSM state enums, the default frame timeout and the
//          command-byte decode helper used by cpu_mem_loader.
// Ports:   none (package).

package cpu_loader_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_RUN   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_GET_ADDR  = 2'b01,
    ST_GET_DATA  = 2'b10,
    ST_READ_WAIT = 2'b11
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // The command lives in the top two bits; the rest of the byte is ignored.
  function automatic cmd_e decode_cmd(input logic [7:0] byte_i);
    return cmd_e'(byte_i[7:6]);
  endfunction

endpackage

// File: rtl/cpu_mem_loader_sync.sv
// rtl/cpu_mem_loader_sync.sv - toggle strobe synchronizer with edge detect
//
// Purpose: brings an asynchronous toggle strobe into the clk domain through two
//          flops, detects any level change with a third flop and emits a
//          one-cycle event while ena is high.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   ena      in   events are suppressed while low
//   strobe_i in   asynchronous toggle strobe
//   event_o  out  one-cycle pulse per strobe level change

module toggle_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic strobe_i,
  output logic event_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       edge_q;
  logic [2:0] arm_q;

  // The synchronizer keeps sampling even while ena is low so that the edge
  // flop always tracks the current strobe level. arm_q holds events off for
  // three cycles after reset or after ena returns, long enough for any level
  // already sitting on the pin to flush through all three flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      arm_q   <= 3'b000;
    end else begin
      sync1_q <= strobe_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      arm_q   <= ena ? {arm_q[1:0], 1'b1} : 3'b000;
    end
  end

  assign event_o = ena & arm_q[2] & (sync2_q ^ edge_q);

endmodule

// File: rtl/cpu_mem_loader.sv
// rtl/cpu_mem_loader.sv - host byte-frame programming and read-back port for CPU RAM
//
// Purpose: accepts command frames over a toggle-strobed byte bus, writes or
//          reads the CPU RAM while the CPU is held, and releases the CPU on RUN.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          design selected; low freezes all state and ignores strobes
//   host_data    frame byte from the host
//   host_strobe  asynchronous toggle strobe, one toggle per byte
//   host_ack     toggles once per accepted byte
//   host_rdata   last read-back word
//   host_rvalid  high from read completion until the next processed byte
//   mem_addr     RAM address
//   mem_wdata    RAM write data
//   mem_we       one-cycle write pulse
//   mem_re       one-cycle read pulse
//   mem_rdata    RAM read data, valid the cycle after mem_re
//   cpu_run      high: CPU owns RAM and executes; low: CPU held

module cpu_mem_loader
  import cpu_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        host_data,
  input  logic              host_strobe,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_run
);

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  logic byte_ev;

  toggle_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .strobe_i (host_strobe),
    .event_o  (byte_ev)
  );

  state_e            state_q, state_d;
  cmd_e              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              run_q, run_d;
  logic              ack_q, ack_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              pend_q, pend_d;
  logic [7:0]        pend_data_q, pend_data_d;

  logic              byte_ok;
  logic [7:0]        byte_v;
  logic              rd_now;
  logic [7:0]        tmo_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      run_q       <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      tmo_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      run_q       <= run_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      tmo_q       <= tmo_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign tmo_inc = tmo_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    run_d       = run_q;
    ack_d       = ack_q;
    rdata_d     = rdata_q;
    rvalid_d    = rvalid_q;
    tmo_d       = tmo_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    byte_ok     = 1'b0;
    byte_v      = host_data;
    rd_now      = 1'b0;

    if (ena) begin
      if (byte_ev) begin
        ack_d = ~ack_q;
      end

      // A byte parked during READ_WAIT is consumed first; if a fresh event
      // lands in the same cycle it takes the parked slot instead of being lost.
      if (state_q != ST_READ_WAIT) begin
        byte_ok = pend_q | byte_ev;
        byte_v  = pend_q ? pend_data_q : host_data;
        if (pend_q) begin
          pend_d = byte_ev;
          if (byte_ev) begin
            pend_data_d = host_data;
          end
        end
      end

      if (byte_ok) begin
        rvalid_d = 1'b0;
        tmo_d    = '0;
      end

      case (state_q)
        ST_IDLE: begin
          if (byte_ok) begin
            case (decode_cmd(byte_v))
              CMD_RUN: run_d = 1'b1;
              CMD_WRITE, CMD_READ: begin
                run_d   = 1'b0;
                cmd_d   = decode_cmd(byte_v);
                state_d = ST_GET_ADDR;
              end
              default: ;
            endcase
          end
        end

        ST_GET_ADDR: begin
          if (byte_ok) begin
            addr_d = byte_v[ADDR_W-1:0];
            if (cmd_q == CMD_READ) begin
              rd_now  = 1'b1;
              state_d = ST_READ_WAIT;
            end else begin
              state_d = ST_GET_DATA;
            end
          end else if (tmo_inc == TIMEOUT_W) begin
            tmo_d   = '0;
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_inc;
          end
        end

        ST_GET_DATA: begin
          if (byte_ok) begin
            wdata_d = byte_v[DATA_W-1:0];
            we_d    = 1'b1;
            state_d = ST_IDLE;
          end else if (tmo_inc == TIMEOUT_W) begin
            tmo_d   = '0;
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_inc;
          end
        end

        ST_READ_WAIT: begin
          rdata_d  = 8'(mem_rdata);
          rvalid_d = 1'b1;
          state_d  = ST_IDLE;
          if (byte_ev) begin
            pend_d      = 1'b1;
            pend_data_d = host_data;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The read strobe is issued in the address-event cycle with the address
  // bypassed straight from the byte, so the RAM returns data during
  // READ_WAIT and host_rvalid rises two cycles after the address event.
  assign mem_addr    = rd_now ? byte_v[ADDR_W-1:0] : addr_q;
  assign mem_re      = rd_now;
  assign mem_we      = we_q;
  assign mem_wdata   = wdata_q;
  assign cpu_run     = run_q;
  assign host_ack    = ack_q;
  assign host_rdata  = rdata_q;
  assign host_rvalid = rvalid_q;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb/tb_cpu_mem_loader.sv - scoreboard testbench for cpu_mem_loader

module tb_cpu_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] host_data = 8'h00;
  logic       host_strobe = 1'b0;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       cpu_run;

  always #5 clk = ~clk;

  cpu_mem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .host_data   (host_data),
    .host_strobe (host_strobe),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .cpu_run     (cpu_run)
  );

  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  wr_t        exp_wr;
  logic [7:0] exp_rd;

  int   compared = 0;
  int   mismatched = 0;
  int   ack_toggles = 0;
  int   we_count = 0;
  int   re_count = 0;
  logic ack_prev = 1'b0;
  logic rvalid_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (host_ack !== ack_prev) ack_toggles++;
      if (mem_we === 1'b1) begin
        we_count++;
        compared++;
        if (wr_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_write: got addr=%0h data=%02h, required no write", mem_addr, mem_wdata);
        end else begin
          exp_wr = wr_q.pop_front();
          if ({mem_addr, mem_wdata} !== {exp_wr.a, exp_wr.d}) begin
            mismatched++;
            $display("FAIL write_sb: got addr=%0h data=%02h, required addr=%0h data=%02h",
                     mem_addr, mem_wdata, exp_wr.a, exp_wr.d);
          end
        end
      end
      if (mem_re === 1'b1) re_count++;
      if (host_rvalid === 1'b1 && rvalid_prev !== 1'b1) begin
        compared++;
        if (rd_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_rvalid: got rdata=%02h, required no read", host_rdata);
        end else begin
          exp_rd = rd_q.pop_front();
          if (host_rdata !== exp_rd) begin
            mismatched++;
            $display("FAIL read_sb: got %02h, required %02h", host_rdata, exp_rd);
          end
        end
      end
      if ((mem_we === 1'b1 || mem_re === 1'b1) && cpu_run === 1'b1) begin
        compared++;
        mismatched++;
        $display("FAIL ram_access_while_run: got we=%b re=%b run=1, required run=0", mem_we, mem_re);
      end
    end
    ack_prev    = host_ack;
    rvalid_prev = host_rvalid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle(input logic [7:0] b);
    host_data   = b;
    host_strobe = ~host_strobe;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic a0;
    logic got;
    got = 1'b0;
    @(negedge clk);
    a0 = host_ack;
    toggle(b);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host_ack !== a0) begin
        got = 1'b1;
        break;
      end
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL ack_timeout: byte %02h got no ack toggle, required toggle within 20 cycles", b);
    end
    tick(2);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ena   = 1'b1;
    tick(3);
    compared++;
    if ({host_ack, host_rvalid, mem_we, mem_re, cpu_run} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got ack/rvalid/we/re/run=%b, required 00000",
               {host_ack, host_rvalid, mem_we, mem_re, cpu_run});
    end
    compared++;
    if ({host_rdata, mem_addr, mem_wdata} !== 20'h0) begin
      mismatched++;
      $display("FAIL reset_buses: got rdata=%02h addr=%0h wdata=%02h, required 0",
               host_rdata, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_write;
    int t0;
    t0 = ack_toggles;
    wr_q.push_back('{a: 4'h5, d: 8'hA7});
    send_byte(8'h40);
    send_byte(8'h05);
    @(negedge clk);
    toggle(8'hA7);
    tick(2);
    compared++;
    if (mem_we !== 1'b0) begin
      mismatched++;
      $display("FAIL write_early: got mem_we=%b at event cycle, required 0", mem_we);
    end
    tick(1);
    compared++;
    if (mem_we !== 1'b1 || mem_addr !== 4'h5 || mem_wdata !== 8'hA7) begin
      mismatched++;
      $display("FAIL write_latency: got we=%b addr=%0h data=%02h, required we=1 addr=5 data=a7",
               mem_we, mem_addr, mem_wdata);
    end
    tick(3);
    compared++;
    if (ack_toggles - t0 !== 3) begin
      mismatched++;
      $display("FAIL write_acks: got %0d ack toggles, required 3", ack_toggles - t0);
    end
  endtask

  task automatic test_read;
    wr_q.push_back('{a: 4'h2, d: 8'h3C});
    send_byte(8'h40);
    send_byte(8'h02);
    send_byte(8'h3C);
    send_byte(8'h80);
    rd_q.push_back(8'h3C);
    @(negedge clk);
    toggle(8'h02);
    tick(2);
    compared++;
    if (mem_re !== 1'b1 || mem_addr !== 4'h2 || host_rvalid !== 1'b0) begin
      mismatched++;
      $display("FAIL read_strobe: got re=%b addr=%0h rvalid=%b, required re=1 addr=2 rvalid=0",
               mem_re, mem_addr, host_rvalid);
    end
    tick(1);
    compared++;
    if (host_rvalid !== 1'b0 || mem_re !== 1'b0) begin
      mismatched++;
      $display("FAIL read_early: got rvalid=%b re=%b one cycle after event, required 0 0", host_rvalid, mem_re);
    end
    tick(1);
    compared++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h3C) begin
      mismatched++;
      $display("FAIL read_latency: got rvalid=%b rdata=%02h, required rvalid=1 rdata=3c",
               host_rvalid, host_rdata);
    end
    send_byte(8'h00);
    compared++;
    if (host_rvalid !== 1'b0 || host_rdata !== 8'h3C) begin
      mismatched++;
      $display("FAIL rvalid_clear: got rvalid=%b rdata=%02h, required rvalid=0 rdata=3c",
               host_rvalid, host_rdata);
    end
  endtask

  task automatic test_run;
    send_byte(8'hC0);
    compared++;
    if (cpu_run !== 1'b1) begin
      mismatched++;
      $display("FAIL run_set: got cpu_run=%b, required 1", cpu_run);
    end
    send_byte(8'h40);
    compared++;
    if (cpu_run !== 1'b0) begin
      mismatched++;
      $display("FAIL run_clear: got cpu_run=%b, required 0", cpu_run);
    end
    wr_q.push_back('{a: 4'h1, d: 8'h11});
    send_byte(8'h01);
    send_byte(8'h11);
    tick(2);
    compared++;
    if (wr_q.size() !== 0 || cpu_run !== 1'b0) begin
      mismatched++;
      $display("FAIL run_write: got %0d pending writes run=%b, required 0 pending run=0", wr_q.size(), cpu_run);
    end
  endtask

  task automatic test_timeout;
    int we0;
    we0 = we_count;
    send_byte(8'h40);
    send_byte(8'h03);
    tick(300);
    send_byte(8'h00);
    tick(5);
    compared++;
    if (we_count !== we0) begin
      mismatched++;
      $display("FAIL timeout_discard: got %0d writes, required 0", we_count - we0);
    end
    wr_q.push_back('{a: 4'h7, d: 8'h99});
    send_byte(8'h40);
    send_byte(8'h07);
    send_byte(8'h99);
    tick(3);
    compared++;
    if (we_count !== we0 + 1 || wr_q.size() !== 0) begin
      mismatched++;
      $display("FAIL timeout_recover: got %0d writes, required 1", we_count - we0);
    end
  endtask

  task automatic test_ena;
    logic a0;
    int   we0;
    int   re0;
    send_byte(8'h40);
    a0  = host_ack;
    we0 = we_count;
    re0 = re_count;
    @(negedge clk);
    ena = 1'b0;
    tick(2);
    toggle(8'h55);
    tick(3);
    toggle(8'h66);
    tick(5);
    compared++;
    if (host_ack !== a0 || we_count !== we0 || re_count !== re0) begin
      mismatched++;
      $display("FAIL ena_low: got ack=%b we=%0d re=%0d, required ack=%b and no RAM access",
               host_ack, we_count - we0, re_count - re0, a0);
    end
    ena = 1'b1;
    tick(6);
    compared++;
    if (host_ack !== a0) begin
      mismatched++;
      $display("FAIL ena_rearm: got ack=%b after ena return, required %b", host_ack, a0);
    end
    wr_q.push_back('{a: 4'h4, d: 8'h5A});
    send_byte(8'h04);
    send_byte(8'h5A);
    tick(2);
    compared++;
    if (wr_q.size() !== 0) begin
      mismatched++;
      $display("FAIL ena_resume: got %0d pending writes, required 0", wr_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int we0;
    send_byte(8'h40);
    send_byte(8'h06);
    compared++;
    if (mem_addr !== 4'h6) begin
      mismatched++;
      $display("FAIL mid_addr: got mem_addr=%0h, required 6", mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({host_ack, host_rvalid, mem_we, mem_re, cpu_run} !== 5'b0 ||
        {host_rdata, mem_addr, mem_wdata} !== 20'h0) begin
      mismatched++;
      $display("FAIL mid_reset: got ack=%b rvalid=%b run=%b rdata=%02h addr=%0h wdata=%02h, required all 0",
               host_ack, host_rvalid, cpu_run, host_rdata, mem_addr, mem_wdata);
    end
    tick(2);
    rst_n = 1'b1;
    tick(6);
    we0 = we_count;
    send_byte(8'h00);
    tick(3);
    compared++;
    if (we_count !== we0) begin
      mismatched++;
      $display("FAIL mid_discard: got %0d writes after reset, required 0", we_count - we0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_run();
    test_timeout();
    test_ena();
    test_reset_mid();
    tick(3);
    compared++;
    if (wr_q.size() !== 0 || rd_q.size() !== 0) begin
      mismatched++;
      $display("FAIL sb_drain: got %0d writes %0d reads outstanding, required 0", wr_q.size(), rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, required completion");
    $fatal(1);
  end

endmodule
